// File: rtl/trigger_cond_pkg.sv
// rtl/trigger_cond_pkg.sv - shared state codes and defaults for the trigger conditioner
package trigger_cond_pkg;

    localparam int DEFAULT_SYNC_STAGES  = 2;
    localparam int DEFAULT_DEBOUNCE_LEN = 10;

    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] CHECK_HI  = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] CHECK_LO  = 2'd3;

    typedef logic [1:0] trig_state_t;

endpackage

// File: rtl/trigger_conditioner_if.sv
// rtl/trigger_conditioner_if.sv - trigger input/config and conditioned status signals
interface trigger_conditioner_if #(
    parameter int DEBOUNCE_BIT_WIDTH = 8,
    parameter int GLITCH_BIT_WIDTH   = 8
);
    logic                          trigger_raw;
    logic [DEBOUNCE_BIT_WIDTH-1:0] debounce_len;
    logic                          glitch_clr;
    logic                          trigger_out;
    logic                          rise_pulse;
    logic                          fall_pulse;
    logic [GLITCH_BIT_WIDTH-1:0]   glitch_cnt;

    modport master (
        output trigger_raw, debounce_len, glitch_clr,
        input  trigger_out, rise_pulse, fall_pulse, glitch_cnt
    );

    modport slave (
        input  trigger_raw, debounce_len, glitch_clr,
        output trigger_out, rise_pulse, fall_pulse, glitch_cnt
    );
endinterface

// File: rtl/trigger_conditioner_sync.sv
// rtl/trigger_conditioner_sync.sv - multi-flop synchroniser for a single asynchronous bit
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];
endmodule

// File: rtl/trigger_conditioner.sv
// rtl/trigger_conditioner.sv - synchronise, debounce and edge-detect a raw trigger line
module trigger_conditioner
    import trigger_cond_pkg::*;
#(
    parameter int SYNC_STAGES        = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_BIT_WIDTH = 8,
    parameter int GLITCH_BIT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    trigger_conditioner_if.slave  bus
);
    localparam int DW = DEBOUNCE_BIT_WIDTH;
    localparam int GW = GLITCH_BIT_WIDTH;

    logic          w_s;
    logic [DW-1:0] w_len_eff;
    logic          w_glitch_ev;

    trig_state_t   r_state;
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_len;
    logic          r_trig;
    logic          r_rise;
    logic          r_fall;
    logic [GW-1:0] r_glitch;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.trigger_raw),
        .q   (w_s)
    );

    // A zero length would qualify on the first sample; treat it as one.
    assign w_len_eff   = (bus.debounce_len == '0) ? DW'(1) : bus.debounce_len;
    assign w_glitch_ev = ((r_state == CHECK_HI) && !w_s) || ((r_state == CHECK_LO) && w_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_len   <= '0;
            r_trig  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (w_s) begin
                        r_state <= CHECK_HI;
                        r_cnt   <= DW'(1);
                        r_len   <= w_len_eff;
                    end
                end
                CHECK_HI: begin
                    if (!w_s) begin
                        r_state <= STABLE_LO;
                    end else if (r_cnt >= r_len) begin
                        r_state <= STABLE_HI;
                        r_trig  <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (!w_s) begin
                        r_state <= CHECK_LO;
                        r_cnt   <= DW'(1);
                        r_len   <= w_len_eff;
                    end
                end
                CHECK_LO: begin
                    if (w_s) begin
                        r_state <= STABLE_HI;
                    end else if (r_cnt >= r_len) begin
                        r_state <= STABLE_LO;
                        r_trig  <= 1'b0;
                        r_fall  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= STABLE_LO;
            endcase
        end
    end

    // Clear wins over the old value but still records a glitch landing on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_glitch <= '0;
        end else if (bus.glitch_clr) begin
            r_glitch <= {{(GW-1){1'b0}}, w_glitch_ev};
        end else if (w_glitch_ev && (r_glitch != '1)) begin
            r_glitch <= r_glitch + 1'b1;
        end
    end

    assign bus.trigger_out = r_trig;
    assign bus.rise_pulse  = r_rise;
    assign bus.fall_pulse  = r_fall;
    assign bus.glitch_cnt  = r_glitch;
endmodule

// File: tb/tb_trigger_conditioner.sv
// tb/tb_trigger_conditioner.sv - directed bench with run-length reference model for trigger_conditioner
`timescale 1ns/1ps
module tb_trigger_conditioner;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int rise_seen   = 0;
    int fall_seen   = 0;

    trigger_conditioner_if #(.DEBOUNCE_BIT_WIDTH(8), .GLITCH_BIT_WIDTH(8)) bus ();

    trigger_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_BIT_WIDTH(8), .GLITCH_BIT_WIDTH(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #500 clk = ~clk;

    // Reference: the level flips once the synchronised line has disagreed with it
    // for L+1 consecutive samples; an interrupted run is a glitch.
    bit m_valid = 0;
    bit m_sq0, m_sq1, m_level, m_rise, m_fall;
    int m_run, m_L, m_glitch;

    always @(posedge clk) begin
        bit s, ev;
        if (rst) begin
            m_valid = 1; m_sq0 = 0; m_sq1 = 0; m_level = 0;
            m_rise = 0; m_fall = 0; m_run = 0; m_L = 1; m_glitch = 0;
        end else begin
            s = m_sq1; m_sq1 = m_sq0; m_sq0 = bus.trigger_raw;
            m_rise = 0; m_fall = 0; ev = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == 1) m_L = (bus.debounce_len == 0) ? 1 : int'(bus.debounce_len);
                if (m_run == m_L + 1) begin
                    m_level = s;
                    if (s) m_rise = 1; else m_fall = 1;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0) ev = 1;
                m_run = 0;
            end
            if (bus.glitch_clr) m_glitch = ev ? 1 : 0;
            else if (ev && m_glitch < 255) m_glitch++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            vectors += 4;
            if (bus.trigger_out !== m_level) begin
                miscompares++;
                $display("FAIL model_trigger_out t=%0t got %b expected %b", $time, bus.trigger_out, m_level);
            end
            if (bus.rise_pulse !== m_rise) begin
                miscompares++;
                $display("FAIL model_rise_pulse t=%0t got %b expected %b", $time, bus.rise_pulse, m_rise);
            end
            if (bus.fall_pulse !== m_fall) begin
                miscompares++;
                $display("FAIL model_fall_pulse t=%0t got %b expected %b", $time, bus.fall_pulse, m_fall);
            end
            if (bus.glitch_cnt !== 8'(m_glitch)) begin
                miscompares++;
                $display("FAIL model_glitch_cnt t=%0t got %0d expected %0d", $time, bus.glitch_cnt, m_glitch);
            end
            if (bus.rise_pulse === 1'b1) rise_seen++;
            if (bus.fall_pulse === 1'b1) fall_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    int r0;

    initial begin
        bus.trigger_raw  = 1'b0;
        bus.debounce_len = 8'd10;
        bus.glitch_clr   = 1'b0;
        rst              = 1'b1;
        tick(2);
        check("reset_trigger_out", int'(bus.trigger_out), 0);
        check("reset_glitch_cnt", int'(bus.glitch_cnt), 0);
        rst = 1'b0;
        tick(1);

        // After tick(k+1) from driving raw, outputs reflect edge e0+k.
        bus.trigger_raw = 1'b1;
        tick(12);
        check("t1_not_yet_e11", int'(bus.trigger_out), 0);
        tick(1);
        check("t1_rise_e12", int'(bus.trigger_out), 1);
        check("t1_rise_pulse_e12", int'(bus.rise_pulse), 1);
        tick(1);
        check("t1_rise_pulse_off", int'(bus.rise_pulse), 0);
        check("t1_glitch_zero", int'(bus.glitch_cnt), 0);
        tick(8);
        bus.trigger_raw = 1'b0;
        tick(15);
        check("t1_back_low", int'(bus.trigger_out), 0);

        for (int i = 0; i < 300; i++) begin
            bus.trigger_raw = 1'b1;
            tick(5);
            bus.trigger_raw = 1'b0;
            tick(5);
            if (i == 0) check("t2_first_glitch", int'(bus.glitch_cnt), 1);
        end
        check("t2_saturated", int'(bus.glitch_cnt), 255);
        check("t2_no_trigger", int'(bus.trigger_out), 0);
        bus.glitch_clr = 1'b1;
        tick(1);
        bus.glitch_clr = 1'b0;
        check("t2_clear_alone", int'(bus.glitch_cnt), 0);

        bus.trigger_raw = 1'b1;
        tick(5);
        bus.trigger_raw = 1'b0;
        tick(2);
        bus.glitch_clr = 1'b1;
        tick(1);
        bus.glitch_clr = 1'b0;
        check("t6_clear_with_glitch", int'(bus.glitch_cnt), 1);
        tick(5);

        bus.trigger_raw = 1'b1;
        tick(20);
        check("t3_high", int'(bus.trigger_out), 1);
        r0 = fall_seen;
        bus.trigger_raw = 1'b0;
        tick(10);
        bus.trigger_raw = 1'b1;
        tick(15);
        check("t3_short_low_kept", int'(bus.trigger_out), 1);
        check("t3_short_low_glitch", int'(bus.glitch_cnt), 2);
        check("t3_no_fall", fall_seen - r0, 0);
        bus.trigger_raw = 1'b0;
        tick(12);
        check("t3_fall_not_yet", int'(bus.trigger_out), 1);
        tick(1);
        check("t3_fall_e12", int'(bus.trigger_out), 0);
        check("t3_fall_pulse", int'(bus.fall_pulse), 1);
        tick(5);

        bus.debounce_len = 8'd0;
        bus.trigger_raw  = 1'b1;
        tick(3);
        check("t4_len0_e2", int'(bus.trigger_out), 0);
        tick(1);
        check("t4_len0_e3", int'(bus.trigger_out), 1);
        bus.trigger_raw = 1'b0;
        tick(6);
        check("t4_len0_low", int'(bus.trigger_out), 0);

        bus.debounce_len = 8'd255;
        bus.trigger_raw  = 1'b1;
        tick(257);
        check("t4_len255_e256", int'(bus.trigger_out), 0);
        tick(1);
        check("t4_len255_e257", int'(bus.trigger_out), 1);
        check("t4_len255_pulse", int'(bus.rise_pulse), 1);
        bus.trigger_raw = 1'b0;
        tick(260);
        check("t4_len255_low", int'(bus.trigger_out), 0);

        bus.debounce_len = 8'd10;
        bus.trigger_raw  = 1'b1;
        tick(5);
        bus.debounce_len = 8'd3;
        tick(7);
        check("t4_midchange_e11", int'(bus.trigger_out), 0);
        tick(1);
        check("t4_midchange_e12", int'(bus.trigger_out), 1);
        bus.trigger_raw  = 1'b0;
        bus.debounce_len = 8'd10;
        tick(15);

        bus.trigger_raw = 1'b1;
        tick(7);
        rst = 1'b1;
        tick(1);
        check("t5_reset_trigger", int'(bus.trigger_out), 0);
        check("t5_reset_glitch", int'(bus.glitch_cnt), 0);
        tick(1);
        rst = 1'b0;
        r0 = rise_seen;
        tick(12);
        check("t5_requal_e11", int'(bus.trigger_out), 0);
        tick(1);
        check("t5_requal_e12", int'(bus.trigger_out), 1);
        tick(3);
        check("t5_one_rise", rise_seen - r0, 1);
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
